// File: rtl/uart_tx_pkg.sv
// Shared types, line levels and the parity helper for the UART transmit serializer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int MAX_DATA_WIDTH = 32;

    // Zero-extended payloads give the same XOR, so one wide argument serves every DATA_WIDTH.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic                      parTyp);
        return (^data) ^ parTyp;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: bit_end_o marks the last UART_CLK cycle of each serial bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] tickCnt_q;
    logic [CW-1:0] tickCnt_d;

    assign bit_end_o = (tickCnt_q == LAST);

    always_comb begin
        tickCnt_d = tickCnt_q + CW'(1);
        if (clear_i || bit_end_o) begin
            tickCnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_serializer.sv
// UART transmit framer fed by a show-ahead FIFO; back-to-back frames without idle bits.
// Optional UART_TX_TWO_STOP_EN: stretch the stop level to two bit periods.
module uart_tx_fifo_serializer
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  UART_CLK,
    input  logic                  RST,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam logic LAST_STOP = 1'b1;
`else
    localparam logic LAST_STOP = 1'b0;
`endif

    tx_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]           bitCnt_q, bitCnt_d;
    logic                    stopCnt_q, stopCnt_d;
    logic                    parEn_q, parEn_d;
    logic                    parTyp_q, parTyp_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    load;
    logic                    bitEnd;
    logic                    tickClear;
    logic                    lastStop;
    logic [MAX_DATA_WIDTH-1:0] dataExt;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i    (UART_CLK),
        .rst_i    (RST),
        .clear_i  (tickClear),
        .bit_end_o(bitEnd)
    );

    always_comb begin
        dataExt                   = '0;
        dataExt[DATA_WIDTH-1:0]   = data_q;
    end

    assign lastStop = (stopCnt_q == LAST_STOP);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        shreg_d   = shreg_q;
        bitCnt_d  = bitCnt_q;
        stopCnt_d = stopCnt_q;
        parEn_d   = parEn_q;
        parTyp_d  = parTyp_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!FIFO_EMPTY) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shreg_d = shreg_q >> 1;
                    if (bitCnt_q == LAST_BIT) begin
                        state_d   = parEn_q ? PARITY : STOP;
                        stopCnt_d = 1'b0;
                    end else begin
                        bitCnt_d = bitCnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    stopCnt_d = 1'b0;
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (!lastStop) begin
                        stopCnt_d = 1'b1;
                    end else if (!FIFO_EMPTY) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load overrides whatever the current state decided; it always opens a fresh frame.
        if (load) begin
            state_d   = START;
            data_d    = FIFO_RD_DATA;
            shreg_d   = FIFO_RD_DATA;
            bitCnt_d  = '0;
            stopCnt_d = 1'b0;
            parEn_d   = PAR_EN;
            parTyp_d  = PAR_TYP;
        end
    end

    // The line level is decoded from the next state so TX_OUT comes straight from a flop.
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_bit(dataExt, parTyp_q);
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d    = (state_d != IDLE);
        tickClear = (state_d != state_q) || (state_q == IDLE);
    end

    always_ff @(posedge UART_CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            shreg_q   <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            parEn_q   <= 1'b0;
            parTyp_q  <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shreg_q   <= shreg_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
            parEn_q   <= parEn_d;
            parTyp_q  <= parTyp_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign FIFO_RD_INC = load & ~RST;
    assign TX_OUT      = tx_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo_serializer.sv
// Bench for uart_tx_fifo_serializer: FIFO model, frame scoreboard and per-bit line checks.
module tb_uart_tx_fifo_serializer;

    localparam int CPB = 16;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clock;
    logic       reset;
    logic       parEn;
    logic       parTyp;
    logic       fifoEmpty;
    logic [7:0] fifoRdData;
    logic       fifoRdInc;
    logic       txOut;
    logic       busy;

    logic [7:0] fifoQ[$];
    frame_t     expQ[$];
    int         testsRun    = 0;
    int         failCount   = 0;
    int         pushCount   = 0;
    int         popCount    = 0;
    int         frameCount  = 0;
    int         emptyPopBad = 0;
    logic       monitorActive = 1'b0;

    uart_tx_fifo_serializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (8)
    ) dut (
        .UART_CLK    (clock),
        .RST         (reset),
        .PAR_EN      (parEn),
        .PAR_TYP     (parTyp),
        .FIFO_EMPTY  (fifoEmpty),
        .FIFO_RD_DATA(fifoRdData),
        .FIFO_RD_INC (fifoRdInc),
        .TX_OUT      (txOut),
        .BUSY        (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic updateFifo();
        fifoEmpty  = (fifoQ.size() == 0);
        fifoRdData = fifoEmpty ? 8'hEE : fifoQ[0];
    endtask

    function automatic frame_t makeFrame(input logic [7:0] d, input logic pe, input logic pt);
        frame_t f;
        f.bits = '1;
        f.n    = 0;
        f.bits[f.n] = 1'b0;
        f.n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[f.n] = d[i];
            f.n++;
        end
        if (pe) begin
            f.bits[f.n] = pt ? ~(^d) : (^d);
            f.n++;
        end
        for (int s = 0; s < NSTOP; s++) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    // Byte goes into the FIFO model; its expected frame uses the parity settings present at load.
    task automatic applyStimulus(input logic [7:0] d);
        fifoQ.push_back(d);
        expQ.push_back(makeFrame(d, parEn, parTyp));
        pushCount++;
        updateFifo();
    endtask

    // FIFO model: pop a cycle's strobe just after the edge the DUT consumed it on.
    always begin
        logic pend;
        @(negedge clock);
        pend = fifoRdInc;
        if (fifoRdInc && fifoEmpty) emptyPopBad++;
        @(posedge clock);
        #1;
        if (pend && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            popCount++;
            updateFifo();
        end
    end

    task automatic runFrames();
        frame_t f;
        logic   nextPulse;
        logic   aborted;
        logic   obs;
        int     busyBad;
        int     popBad;
        monitorActive = 1'b1;
        aborted = 1'b0;
        do begin
            nextPulse = 1'b0;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedFrame", 1, 0);
                @(negedge clock);
                monitorActive = 1'b0;
                return;
            end
            f       = expQ.pop_front();
            busyBad = 0;
            popBad  = 0;
            for (int b = 0; b < f.n && !aborted; b++) begin
                obs = f.bits[b];
                for (int c = 0; c < CPB && !aborted; c++) begin
                    @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                    end else begin
                        if (txOut !== f.bits[b]) obs = txOut;
                        if (busy !== 1'b1) busyBad++;
                        if (fifoRdInc) begin
                            if (b == f.n - 1 && c == CPB - 1) nextPulse = 1'b1;
                            else popBad++;
                        end
                    end
                end
                if (!aborted) checkOutput($sformatf("txBit%0d", b), obs, f.bits[b]);
            end
            if (!aborted) begin
                checkOutput("busyInFrame", busyBad, 0);
                checkOutput("popInFrame", popBad, 0);
                frameCount++;
            end
        end while (nextPulse && !aborted);
        if (!aborted) begin
            @(negedge clock);
            checkOutput("busyAfterFrame", busy, 0);
            checkOutput("txAfterFrame", txOut, 1);
        end
        monitorActive = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (fifoRdInc && !reset) runFrames();
        end
    end

    task automatic waitIdle();
        logic done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (i > 0 && !monitorActive && !busy && fifoQ.size() == 0) done = 1'b1;
        end
        if (!done) checkOutput("idleTimeout", 1, 0);
    endtask

    initial begin
        int   idleBad;
        int   popsBefore;
        logic found;

        reset  = 1'b1;
        parEn  = 1'b0;
        parTyp = 1'b0;
        updateFifo();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rstTx", txOut, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstInc", fifoRdInc, 0);
        @(posedge clock); #2;
        reset = 1'b0;

        idleBad = 0;
        repeat (500) begin
            @(negedge clock);
            if (txOut !== 1'b1 || busy !== 1'b0 || fifoRdInc !== 1'b0) idleBad++;
        end
        checkOutput("idleHold", idleBad, 0);
        checkOutput("idlePops", popCount, 0);

        @(posedge clock); #2;
        parEn = 1'b1; parTyp = 1'b0;
        applyStimulus(8'hA5);
        waitIdle();
        @(posedge clock); #2;
        parTyp = 1'b1;
        applyStimulus(8'hA5);
        waitIdle();
        @(posedge clock); #2;
        parEn = 1'b0;
        applyStimulus(8'h00);
        waitIdle();

        @(posedge clock); #2;
        parEn = 1'b1; parTyp = 1'b0;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        waitIdle();

        @(posedge clock); #2;
        parEn = 1'b0;
        applyStimulus(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (fifoRdInc) found = 1'b1;
        end
        checkOutput("rstLoadSeen", found, 1);
        repeat (70) @(negedge clock);
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("midRstTx", txOut, 1);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstInc", fifoRdInc, 0);
        popsBefore = popCount;
        @(posedge clock); #2;
        reset = 1'b0;
        idleBad = 0;
        repeat (50) begin
            @(negedge clock);
            if (busy !== 1'b0 || txOut !== 1'b1 || fifoRdInc !== 1'b0) idleBad++;
        end
        checkOutput("postRstIdle", idleBad, 0);
        checkOutput("postRstPops", popCount, popsBefore);

        @(posedge clock); #2;
        parEn = 1'b1; parTyp = 1'b0;
        applyStimulus(8'h01);
        repeat (60) @(negedge clock);
        @(posedge clock); #2;
        parTyp = 1'b1;
        parEn  = 1'b0;
        waitIdle();
        @(posedge clock); #2;
        parEn = 1'b1;
        applyStimulus(8'h01);
        waitIdle();

        @(posedge clock); #2;
        parEn  = 1'($urandom_range(0, 1));
        parTyp = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(0, 255)));
        waitIdle();

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        checkOutput("totalPops", popCount, pushCount);
        checkOutput("framesDone", frameCount, pushCount - 1);
        checkOutput("popWhileEmpty", emptyPopBad, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
